sseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It sequences one shared hex2sseg decoder across DIGITS digit positions and drives the active-low anode enables. A blanking interval between digits removes ghosting. The displayed value comes from a shadow register and is applied only at frame boundaries, so a displayed frame never mixes old and new digits. Sits between the user logic producing a hex value and the board display pins.

---
 rtl/sseg_scan_ctrl_pkg.sv | 8 +
 rtl/sseg_scan_ctrl_hex2sseg.sv | 9 +
 rtl/sseg_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sseg_scan_ctrl_pkg.sv
// sseg_pkg: scan states and constants shared by the seven-segment scan controller.
package sseg_pkg;
  typedef enum logic [1:0] {OFF, BLANK, SHOW} scan_state_t;
  localparam logic [6:0] SSEG_BLANK = 7'h7F;
  function automatic logic [7:0] an_off(input int n);
    return 8'((9'd1 << n) - 9'd1);
  endfunction
endpackage

// File: rtl/sseg_scan_ctrl_hex2sseg.sv
// hex2sseg: hex nibble to active-low gfedcba segment code.
module hex2sseg (
  input  logic [3:0] hex_i,
  output logic [6:0] sseg_o
);
  localparam logic [6:0] LUT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  assign sseg_o = LUT[hex_i];
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: tear-free multiplexed scan of a common-anode seven-segment display.
// Define SSEG_LZB_EN to blank leading-zero digits.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic [6:0]            sseg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [DIGITS-1:0] AN_OFF = DIGITS'(an_off(DIGITS));
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  scan_state_t         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          sseg_q, sseg_d, dec;
  logic                dp_q, dp_d, frame_q, frame_d;
  logic                copy, blank;
  logic [3:0]          nib;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    copy    = 1'b0;
    case (state_q)
      OFF: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = BLANK;
          copy    = 1'b1;
        end
      end
      BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      SHOW: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
        idx_d   = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
        copy    = idx_q == IDX_LAST;
      end
      default: state_d = OFF;
    endcase
    if (!en_i) begin
      state_d = OFF;
      idx_d   = '0;
      cnt_d   = '0;
      copy    = 1'b0;
    end
    shadow_val_d = load_i ? value_i : shadow_val_q;
    shadow_dp_d  = load_i ? dp_i : shadow_dp_q;
    // shadow_*_d already carries a same-cycle load, giving the bypass on copy
    active_val_d = copy ? shadow_val_d : active_val_q;
    active_dp_d  = copy ? shadow_dp_d : active_dp_q;
    frame_d      = state_d == SHOW && idx_d == IDX_LAST && cnt_d == SHOW_LAST;
  end

  hex2sseg u_dec (.hex_i(nib), .sseg_o(dec));

  always_comb begin
    nib = 4'(active_val_d >> (4 * idx_d));
`ifdef SSEG_LZB_EN
    blank = idx_d != '0 && (active_val_d >> (4 * idx_d)) == '0 && !active_dp_d[idx_d];
`else
    blank = 1'b0;
`endif
    an_d   = (state_d == SHOW && !blank) ? ~(DIGITS'(1) << idx_d) : AN_OFF;
    sseg_d = (state_d == OFF || blank) ? SSEG_BLANK : dec;
    dp_d   = (state_d == OFF || blank) ? 1'b1 : ~active_dp_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      an_q         <= AN_OFF;
      sseg_q       <= SSEG_BLANK;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign sseg_o  = sseg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: scoreboard bench for sseg_scan_ctrl with DIGITS=4, DIV=8, BLANK_CYC=2.
module tb_sseg_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1, en_i = 1'b0, load_i = 1'b0;
  logic [15:0] value_i = '0;
  logic [3:0]  dp_i = '0;
  logic [6:0]  sseg_o;
  logic        dp_o, frame_o;
  logic [3:0]  an_o;

  typedef struct {
    int         sc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_mis = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .value_i(value_i), .load_i(load_i),
    .dp_i(dp_i), .sseg_o(sseg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h7: return 7'b1111000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic push(input int sc, input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic fr);
    exp_t e;
    e.sc = sc; e.an = an; e.seg = seg; e.dp = dp; e.fr = fr;
    q.push_back(e);
  endtask

  // first n cycles of digit k's 8-cycle slot: 2 blank, then 6 shown
  task automatic push_slot(input int sc, input int k, input logic [15:0] val, input logic [3:0] dp4, input int n);
    logic       bl;
    logic [3:0] nib;
    nib = 4'(val >> (4 * k));
`ifdef SSEG_LZB_EN
    bl = k > 0 && (val >> (4 * k)) == 16'h0 && !dp4[k];
`else
    bl = 1'b0;
`endif
    for (int i = 0; i < n; i++)
      push(sc, (i < 2 || bl) ? 4'hF : ~(4'b0001 << k), bl ? 7'h7F : seg7(nib),
           bl ? 1'b1 : ~dp4[k], k == 3 && i == 7);
  endtask

  task automatic push_frame(input int sc, input logic [15:0] val, input logic [3:0] dp4);
    for (int k = 0; k < 4; k++) push_slot(sc, k, val, dp4, 8);
  endtask

  task automatic push_off(input int sc, input int n);
    for (int i = 0; i < n; i++) push(sc, 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d expected samples left, required 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (an_o !== e.an || sseg_o !== e.seg || dp_o !== e.dp || frame_o !== e.fr) begin
        n_mis++;
        $display("FAIL sc%0d outputs: got an=%b seg=%b dp=%b fr=%b, want an=%b seg=%b dp=%b fr=%b",
                 e.sc, an_o, sseg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.fr);
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk);
    push_off(0, 2);
    drain;
    // release reset and start with a loaded 3210 (bypass on OFF->BLANK)
    #1 rst_n = 1'b1; en_i = 1'b1; load_i = 1'b1; value_i = 16'h3210;
    @(posedge clk);
    for (int f = 0; f < 3; f++) push_frame(1, 16'h3210, 4'h0);
    #1 load_i = 1'b0;
    drain;
    // tear-free load during digit 1
    push_frame(3, 16'h3210, 4'h0);
    repeat (10) @(posedge clk);
    #1 load_i = 1'b1; value_i = 16'h1111;
    @(posedge clk);
    #1 load_i = 1'b0;
    push_frame(3, 16'h1111, 4'h0);
    drain;
    // enable drop in digit 2 SHOW, load while off, re-enable with dp on digit 2
    push_slot(4, 0, 16'h1111, 4'h0, 8);
    push_slot(4, 1, 16'h1111, 4'h0, 8);
    push_slot(4, 2, 16'h1111, 4'h0, 5);
    push_off(4, 3);
    push_frame(5, 16'h3210, 4'b0100);
    repeat (20) @(posedge clk);
    #1 en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 load_i = 1'b1; value_i = 16'h3210; dp_i = 4'b0100;
    @(posedge clk);
    #1 load_i = 1'b0; en_i = 1'b1;
    drain;
    // leading zeros, last load wins, bypass at frame wrap
    push_frame(6, 16'h3210, 4'b0100);
    push_frame(6, 16'h0070, 4'h0);
    push_frame(7, 16'h7302, 4'b0001);
    repeat (5) @(posedge clk);
    #1 load_i = 1'b1; value_i = 16'h0070; dp_i = 4'h0;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (38) @(posedge clk);
    #1 load_i = 1'b1; value_i = 16'h1111;
    @(posedge clk);
    #1 load_i = 1'b0;
    repeat (18) @(posedge clk);
    #1 load_i = 1'b1; value_i = 16'h7302; dp_i = 4'b0001;
    @(posedge clk);
    #1 load_i = 1'b0;
    drain;
    // asynchronous reset mid-slot clears shadow
    push_slot(8, 0, 16'h7302, 4'b0001, 3);
    push_off(8, 3);
    push_frame(9, 16'h0000, 4'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
